conv33_window_gen: RTL and testbench

//  Producer side of the conv33 datapath. Accepts a raster-order pixel stream, one pixel
//  per in_valid cycle, and buffers two image rows in line buffers. Emits every valid
//  (unpadded) 3x3 window on data_r_c with a conv33_en strobe, for direct connection to
//  the conv33 calc block. Weights, bias and scale are supplied elsewhere.

---
 rtl/conv33_window_gen.sv | 107 ++++++++++
 tb/tb_conv33_window_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv33_window_gen.sv
// conv33_window_gen: raster pixel stream -> every valid 3x3 window, using two row line buffers.
// Optional CONV33_STRIDE2_EN: emit only windows whose top-left pixel sits on an even (row, col).
module conv33_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] data_0_0,
    output logic [DATA_WIDTH-1:0] data_0_1,
    output logic [DATA_WIDTH-1:0] data_0_2,
    output logic [DATA_WIDTH-1:0] data_1_0,
    output logic [DATA_WIDTH-1:0] data_1_1,
    output logic [DATA_WIDTH-1:0] data_1_2,
    output logic [DATA_WIDTH-1:0] data_2_0,
    output logic [DATA_WIDTH-1:0] data_2_1,
    output logic [DATA_WIDTH-1:0] data_2_2,
    output logic                  conv33_en,
    output logic                  frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Position of the last window emitted in a frame (bottom-right anchor pixel).
`ifdef CONV33_STRIDE2_EN
    localparam int LAST_R = 2 + ((IMG_H - 3) / 2) * 2;
    localparam int LAST_C = 2 + ((IMG_W - 3) / 2) * 2;
`else
    localparam int LAST_R = IMG_H - 1;
    localparam int LAST_C = IMG_W - 1;
`endif

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] lb0 [IMG_W];
    logic [DATA_WIDTH-1:0] lb1 [IMG_W];
    logic [DATA_WIDTH-1:0] lb0_rd;
    logic [DATA_WIDTH-1:0] lb1_rd;
    logic                  col_last;
    logic                  row_last;
    logic                  emit;
    logic                  last_win;

    always_comb begin
        lb0_rd   = lb0[col];
        lb1_rd   = lb1[col];
        col_last = (col == CW'(IMG_W - 1));
        row_last = (row == RW'(IMG_H - 1));
        emit     = in_valid && (row >= RW'(2)) && (col >= CW'(2));
`ifdef CONV33_STRIDE2_EN
        // (r-2) and (c-2) even is the same as r and c even
        emit     = emit && !row[0] && !col[0];
`endif
        last_win = emit && (row == RW'(LAST_R)) && (col == CW'(LAST_C));
    end

    // Line-buffer RAM is intentionally not reset; rows 0-1 refill it before any emit.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1[col] <= lb0_rd;
            lb0[col] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            conv33_en  <= 1'b0;
            frame_done <= 1'b0;
            data_0_0   <= '0;
            data_0_1   <= '0;
            data_0_2   <= '0;
            data_1_0   <= '0;
            data_1_1   <= '0;
            data_1_2   <= '0;
            data_2_0   <= '0;
            data_2_1   <= '0;
            data_2_2   <= '0;
        end else begin
            conv33_en  <= emit;
            frame_done <= last_win;
            if (in_valid) begin
                data_0_0 <= data_0_1;
                data_0_1 <= data_0_2;
                data_0_2 <= lb1_rd;
                data_1_0 <= data_1_1;
                data_1_1 <= data_1_2;
                data_1_2 <= lb0_rd;
                data_2_0 <= data_2_1;
                data_2_1 <= data_2_2;
                data_2_2 <= in_data;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv33_window_gen.sv
// Bench for conv33_window_gen: a 4x4 and a 28x28 instance checked against a frame-memory model.
// Honours CONV33_STRIDE2_EN the same way the design does.
module tb_conv33_window_gen;

    localparam int SW = 4;
    localparam int LW = 28;
`ifdef CONV33_STRIDE2_EN
    localparam int NS = 1;
    localparam int NL = 169;
`else
    localparam int NS = 4;
    localparam int NL = 676;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] vin;
    logic [7:0] din [2];
    logic [7:0] dw  [2][9];
    logic       en  [2];
    logic       fd  [2];

    int n_cmp;
    int n_bad;
    int cnt_en [2];
    int cnt_fd [2];

    logic [7:0] lit_first [9];
    logic [7:0] lit_last  [9];
    bit         lit_on;

    // model: whole frame kept in memory, windows read straight out of it
    logic [7:0] img  [2][LW][LW];
    int         mr   [2];
    int         mc   [2];
    int         nwin [2];
    int         xr   [2];
    int         xc   [2];
    logic       xen  [2];
    logic       xfd  [2];
    logic       xhold[2];
    logic [7:0] xwin [2][9];

    conv33_window_gen #(.DATA_WIDTH(8), .IMG_W(SW), .IMG_H(SW)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .in_data(din[0]),
        .data_0_0(dw[0][0]), .data_0_1(dw[0][1]), .data_0_2(dw[0][2]),
        .data_1_0(dw[0][3]), .data_1_1(dw[0][4]), .data_1_2(dw[0][5]),
        .data_2_0(dw[0][6]), .data_2_1(dw[0][7]), .data_2_2(dw[0][8]),
        .conv33_en(en[0]), .frame_done(fd[0])
    );

    conv33_window_gen #(.DATA_WIDTH(8), .IMG_W(LW), .IMG_H(LW)) u_large (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .in_data(din[1]),
        .data_0_0(dw[1][0]), .data_0_1(dw[1][1]), .data_0_2(dw[1][2]),
        .data_1_0(dw[1][3]), .data_1_1(dw[1][4]), .data_1_2(dw[1][5]),
        .data_2_0(dw[1][6]), .data_2_1(dw[1][7]), .data_2_2(dw[1][8]),
        .conv33_en(en[1]), .frame_done(fd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dim(input int k);
        return (k == 0) ? SW : LW;
    endfunction

    function automatic int total_wins(input int k);
`ifdef CONV33_STRIDE2_EN
        return ((dim(k) - 3) / 2 + 1) * ((dim(k) - 3) / 2 + 1);
`else
        return (dim(k) - 2) * (dim(k) - 2);
`endif
    endfunction

    function automatic bit emit_at(input int r, input int c);
`ifdef CONV33_STRIDE2_EN
        return r >= 2 && c >= 2 && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`else
        return r >= 2 && c >= 2;
`endif
    endfunction

    function automatic logic [7:0] pix(input int k, input int r, input int c,
                                       input int cr, input int cc);
        if (r == cr && c == cc) return din[k];
        return img[k][r][c];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mr[k] <= 0; mc[k] <= 0; nwin[k] <= 0;
                xen[k] <= 1'b0; xfd[k] <= 1'b0; xhold[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                xen[k] <= 1'b0;
                xfd[k] <= 1'b0;
                if (vin[k]) begin
                    img[k][mr[k]][mc[k]] <= din[k];
                    if (emit_at(mr[k], mc[k])) begin
                        xen[k]   <= 1'b1;
                        xhold[k] <= 1'b1;
                        xr[k]    <= mr[k];
                        xc[k]    <= mc[k];
                        for (int i = 0; i < 9; i++)
                            xwin[k][i] <= pix(k, mr[k] - 2 + i / 3, mc[k] - 2 + i % 3, mr[k], mc[k]);
                        xfd[k]   <= (nwin[k] + 1 == total_wins(k));
                        nwin[k]  <= nwin[k] + 1;
                    end else begin
                        xhold[k] <= 1'b0;
                    end
                    if (mc[k] == dim(k) - 1) begin
                        mc[k] <= 0;
                        if (mr[k] == dim(k) - 1) begin
                            mr[k]   <= 0;
                            nwin[k] <= 0;
                        end else begin
                            mr[k] <= mr[k] + 1;
                        end
                    end else begin
                        mc[k] <= mc[k] + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] t=%0t got=%0h want=%0h", nm, idx, $time, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    chk("rst_en", k, 32'(en[k]), 0);
                    chk("rst_fd", k, 32'(fd[k]), 0);
                    for (int i = 0; i < 9; i++) chk("rst_win", k * 10 + i, 32'(dw[k][i]), 0);
                end else begin
                    chk("en", k, 32'(en[k]), 32'(xen[k]));
                    chk("frame_done", k, 32'(fd[k]), 32'(xfd[k]));
                    if (xhold[k])
                        for (int i = 0; i < 9; i++) chk("win", k * 10 + i, 32'(dw[k][i]), 32'(xwin[k][i]));
                    if (en[k]) cnt_en[k]++;
                    if (fd[k]) cnt_fd[k]++;
                    if (k == 0 && lit_on && xen[0] && xr[0] == 2 && xc[0] == 2)
                        for (int i = 0; i < 9; i++) chk("lit_first", i, 32'(dw[0][i]), 32'(lit_first[i]));
                    if (k == 0 && lit_on && xfd[0])
                        for (int i = 0; i < 9; i++) chk("lit_last", i, 32'(dw[0][i]), 32'(lit_last[i]));
                end
            end
        end
    endtask

    task automatic put(input int k, input bit v, input logic [7:0] d);
        @(posedge clk);
        #1;
        vin    = '0;
        vin[k] = v;
        din[k] = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(0, 1'b0, 8'h00);
    endtask

    function automatic logic [7:0] lval(input int f, input int r, input int c);
        return 8'((f * 37 + r * 5 + c * 3) % 256);
    endfunction

    task automatic send_large(input int f, input int npix);
        for (int p = 0; p < npix; p++) put(1, 1'b1, lval(f, p / LW, p % LW));
    endtask

    initial begin
        int b_en, b_fd;
        n_cmp = 0; n_bad = 0;
        cnt_en[0] = 0; cnt_en[1] = 0; cnt_fd[0] = 0; cnt_fd[1] = 0;
        rst_n = 1'b0; vin = '0; din[0] = '0; din[1] = '0; lit_on = 1'b0;
        fork
            compare_loop();
        join_none
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // T1: 4x4 ramp, continuous
        lit_first = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
`ifdef CONV33_STRIDE2_EN
        lit_last  = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
`else
        lit_last  = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
`endif
        lit_on = 1'b1;
        b_en = cnt_en[0]; b_fd = cnt_fd[0];
        for (int p = 0; p < 16; p++) put(0, 1'b1, 8'(p));
        idle(3);
        chk("t1_strobes", 0, 32'(cnt_en[0] - b_en), NS);
        chk("t1_done", 0, 32'(cnt_fd[0] - b_fd), 1);

        // T2: same frame, valid toggling
        b_en = cnt_en[0]; b_fd = cnt_fd[0];
        for (int p = 0; p < 16; p++) begin
            put(0, 1'b1, 8'(p));
            idle(1);
        end
        idle(3);
        chk("t2_strobes", 0, 32'(cnt_en[0] - b_en), NS);
        chk("t2_done", 0, 32'(cnt_fd[0] - b_fd), 1);

        // T5: signed extremes checkerboard
        lit_first = '{8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80};
        lit_last  = '{8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80};
        b_en = cnt_en[0];
        for (int p = 0; p < 16; p++)
            put(0, 1'b1, (((p / 4) + (p % 4)) % 2 == 0) ? 8'h80 : 8'h7F);
        idle(3);
        chk("t5_strobes", 0, 32'(cnt_en[0] - b_en), NS);
        lit_on = 1'b0;

        // T3: two 28x28 frames back to back
        b_en = cnt_en[1]; b_fd = cnt_fd[1];
        send_large(0, LW * LW);
        send_large(1, LW * LW);
        idle(3);
        chk("t3_strobes", 1, 32'(cnt_en[1] - b_en), 2 * NL);
        chk("t3_done", 1, 32'(cnt_fd[1] - b_fd), 2);

        // T4: reset after pixel (10,5), then a full frame
        send_large(2, 10 * LW + 6);
        idle(1);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        b_en = cnt_en[1]; b_fd = cnt_fd[1];
        send_large(3, LW * LW);
        idle(3);
        chk("t4_strobes", 1, 32'(cnt_en[1] - b_en), NL);
        chk("t4_done", 1, 32'(cnt_fd[1] - b_fd), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
